edge_bbox_stats: RTL

EDGE_BBOX_STATS -- requirements
Module: edge_bbox_stats

---
 rtl/edge_stats_pkg.sv | 14 +
 rtl/frame_pos_counter.sv | 65 ++++++
 rtl/edge_bbox_stats.sv | 132 +++++++++++++
 3 files changed

// File: rtl/edge_stats_pkg.sv
// Shared widths and FSM encoding for the edge bounding-box statistics block.
package edge_stats_pkg;

    localparam int DEF_X_BITS   = 11;
    localparam int DEF_Y_BITS   = 11;
    localparam int DEF_CNT_BITS = 22;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

endpackage

// File: rtl/frame_pos_counter.sv
// Detects vsync/href edges and tracks the column/row position of the
// current pixel; both coordinates saturate at all-ones.
module frame_pos_counter
    import edge_stats_pkg::*;
#(
    parameter int X_BITS = DEF_X_BITS,
    parameter int Y_BITS = DEF_Y_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vsync,
    input  logic              href,
    input  logic              clken,
    input  logic              count_rows,
    output logic              pix_valid,
    output logic              vsync_rise,
    output logic              vsync_fall,
    output logic [X_BITS-1:0] x,
    output logic [Y_BITS-1:0] y
);

    logic              vsync_d_q;
    logic              href_d_q;
    logic              armed_q;
    logic [X_BITS-1:0] x_q;
    logic [Y_BITS-1:0] y_q;
    logic              href_fall;

    assign pix_valid  = vsync & href & clken;
    // A frame already under way when reset releases must not look like a
    // new frame start, so rising edges count only after vsync was seen low.
    assign vsync_rise = vsync & ~vsync_d_q & armed_q;
    assign vsync_fall = ~vsync & vsync_d_q;
    assign href_fall  = ~href & href_d_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_d_q <= 1'b0;
            href_d_q  <= 1'b0;
            armed_q   <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
        end else begin
            vsync_d_q <= vsync;
            href_d_q  <= href;
            if (!vsync) begin
                armed_q <= 1'b1;
            end
            if (href_fall) begin
                x_q <= '0;
            end else if (pix_valid && (x_q != '1)) begin
                x_q <= x_q + 1'b1;
            end
            if (vsync_rise) begin
                y_q <= '0;
            end else if (href_fall && count_rows && (y_q != '1)) begin
                y_q <= y_q + 1'b1;
            end
        end
    end

    assign x = x_q;
    assign y = y_q;

endmodule

// File: rtl/edge_bbox_stats.sv
// Per-frame edge-pixel count and bounding box of a binary edge stream,
// published with a one-cycle stats_valid pulse after each frame ends.
module edge_bbox_stats
    import edge_stats_pkg::*;
#(
    parameter int X_BITS   = DEF_X_BITS,
    parameter int Y_BITS   = DEF_Y_BITS,
    parameter int CNT_BITS = DEF_CNT_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                per_frame_vsync,
    input  logic                per_frame_href,
    input  logic                per_frame_clken,
    input  logic                per_img_Bit,
    output logic [CNT_BITS-1:0] edge_count,
    output logic [X_BITS-1:0]   x_min,
    output logic [X_BITS-1:0]   x_max,
    output logic [Y_BITS-1:0]   y_min,
    output logic [Y_BITS-1:0]   y_max,
    output logic                bbox_empty,
    output logic                stats_valid
);

    state_t              state_q, state_d;
    logic                pix_valid, vsync_rise, vsync_fall;
    logic [X_BITS-1:0]   x;
    logic [Y_BITS-1:0]   y;
    logic                enter_active, hit, report_load;

    logic [CNT_BITS-1:0] cnt_q;
    logic [X_BITS-1:0]   xmin_q, xmax_q;
    logic [Y_BITS-1:0]   ymin_q, ymax_q;
    logic                seen_q;

    logic [CNT_BITS-1:0] edge_count_q;
    logic [X_BITS-1:0]   x_min_q, x_max_q;
    logic [Y_BITS-1:0]   y_min_q, y_max_q;
    logic                bbox_empty_q, stats_valid_q;

    frame_pos_counter #(
        .X_BITS (X_BITS),
        .Y_BITS (Y_BITS)
    ) u_pos (
        .clk        (clk),
        .rst        (rst),
        .vsync      (per_frame_vsync),
        .href       (per_frame_href),
        .clken      (per_frame_clken),
        .count_rows (state_q == ST_ACTIVE),
        .pix_valid  (pix_valid),
        .vsync_rise (vsync_rise),
        .vsync_fall (vsync_fall),
        .x          (x),
        .y          (y)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (vsync_rise) state_d = ST_ACTIVE;
            ST_ACTIVE: if (vsync_fall) state_d = ST_REPORT;
            ST_REPORT: state_d = vsync_rise ? ST_ACTIVE : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign enter_active = (state_d == ST_ACTIVE) && (state_q != ST_ACTIVE);
    assign hit          = (state_q == ST_ACTIVE) && pix_valid && per_img_Bit;
    // Outputs load on the edge into REPORT so they are visible with the pulse.
    assign report_load  = (state_q == ST_ACTIVE) && (state_d == ST_REPORT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            xmin_q  <= '1;
            xmax_q  <= '0;
            ymin_q  <= '1;
            ymax_q  <= '0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (enter_active) begin
                cnt_q  <= '0;
                xmin_q <= '1;
                xmax_q <= '0;
                ymin_q <= '1;
                ymax_q <= '0;
                seen_q <= 1'b0;
            end else if (hit) begin
                if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
                if (x < xmin_q)  xmin_q <= x;
                if (x > xmax_q)  xmax_q <= x;
                if (y < ymin_q)  ymin_q <= y;
                if (y > ymax_q)  ymax_q <= y;
                seen_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_count_q  <= '0;
            x_min_q       <= '0;
            x_max_q       <= '0;
            y_min_q       <= '0;
            y_max_q       <= '0;
            bbox_empty_q  <= 1'b1;
            stats_valid_q <= 1'b0;
        end else begin
            stats_valid_q <= report_load;
            if (report_load) begin
                edge_count_q <= cnt_q;
                x_min_q      <= seen_q ? xmin_q : '0;
                x_max_q      <= seen_q ? xmax_q : '0;
                y_min_q      <= seen_q ? ymin_q : '0;
                y_max_q      <= seen_q ? ymax_q : '0;
                bbox_empty_q <= ~seen_q;
            end
        end
    end

    assign edge_count  = edge_count_q;
    assign x_min       = x_min_q;
    assign x_max       = x_max_q;
    assign y_min       = y_min_q;
    assign y_max       = y_max_q;
    assign bbox_empty  = bbox_empty_q;
    assign stats_valid = stats_valid_q;

endmodule
